// File: rtl/display_link_rx_pkg.sv
// display_link_rx_pkg
//   Constants and types shared between the display link receiver and the
//   display transmitter: default geometry, synchroniser depth, minimum link
//   phase length in system clock cycles, and the row word type.
package display_link_rx_pkg;

    localparam int unsigned COLS_DEF        = 8;
    localparam int unsigned ROWS_DEF        = 8;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    // Each serial_clock/display_clk phase must last at least this many clk
    // cycles so the synchroniser and edge detector can see it.
    localparam int unsigned MIN_PHASE_CLKS  = SYNC_STAGES_DEF + 1;

    typedef logic [COLS_DEF-1:0] row_word_t;

endpackage

// File: rtl/display_link_rx_sync_edge.sv
// link_sync_edge
//   STAGES-deep synchroniser followed by one edge-detect flop for a single
//   asynchronous link wire.
//   Ports:
//     clk     in  system clock
//     rst_n   in  asynchronous active-low reset
//     d_i     in  raw link wire
//     level_o out synchronised level
//     rise_o  out one-cycle pulse on a synchronised rising edge
module link_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/display_link_rx.sv
// display_link_rx
//   Receiving end of the serial display link. Oversamples the five link
//   wires in the clk domain, deserialises one row (MSB first) per
//   display_clk rising edge and presents it with its row index.
//   Ports:
//     clk, reset                   system clock, async active-low reset
//     serial_clock, data_in        link bit clock and serial data
//     data_enable                  gates serial_clock edges
//     display_clk                  rising edge latches the current row
//     clear                        level: clears shift path and row counter
//     row_data, row_index          last latched row and its index
//     row_valid                    one-cycle pulse on every latch
//     len_error                    with row_valid when bit count != COLS
module display_link_rx
    import display_link_rx_pkg::*;
#(
    parameter int unsigned COLS        = COLS_DEF,
    parameter int unsigned ROWS        = ROWS_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      serial_clock,
    input  logic                      data_in,
    input  logic                      data_enable,
    input  logic                      display_clk,
    input  logic                      clear,
    output logic [COLS-1:0]           row_data,
    output logic [$clog2(ROWS)-1:0]   row_index,
    output logic                      row_valid,
    output logic                      len_error
);

    localparam int unsigned IDX_W = $clog2(ROWS);
    localparam int unsigned CNT_W = $clog2(COLS + 2);

    logic sclk_lvl, sclk_rise, din_lvl, din_rise, en_lvl, en_rise;
    logic dclk_lvl, dclk_rise, clr_lvl, clr_rise;
    logic unused_sync;

    // Equal synchroniser depth on all wires keeps data_in/data_enable
    // aligned with the serial_clock edge they belong to.
    link_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst_n(reset), .d_i(serial_clock), .level_o(sclk_lvl), .rise_o(sclk_rise));
    link_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_din (
        .clk(clk), .rst_n(reset), .d_i(data_in), .level_o(din_lvl), .rise_o(din_rise));
    link_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_en (
        .clk(clk), .rst_n(reset), .d_i(data_enable), .level_o(en_lvl), .rise_o(en_rise));
    link_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_dclk (
        .clk(clk), .rst_n(reset), .d_i(display_clk), .level_o(dclk_lvl), .rise_o(dclk_rise));
    link_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clr (
        .clk(clk), .rst_n(reset), .d_i(clear), .level_o(clr_lvl), .rise_o(clr_rise));

    assign unused_sync = ^{sclk_lvl, din_rise, en_rise, dclk_lvl, clr_rise};

    logic [COLS-1:0]  shreg_q, shreg_d, shifted;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d, cnt_inc;
    logic [IDX_W-1:0] next_row_q, next_row_d;
    logic [COLS-1:0]  row_data_q, row_data_d;
    logic [IDX_W-1:0] row_index_q, row_index_d;
    logic             row_valid_d, len_error_d;
    logic             row_valid_q, len_error_q;
    logic             shift_ev;

    assign shift_ev = sclk_rise & en_lvl;

    // Shift and latch in one cycle: the latch sees the freshly shifted bit
    // and its count, so both are computed before the latch decision.
    always_comb begin
        shifted = shift_ev ? {shreg_q[COLS-2:0], din_lvl} : shreg_q;
        cnt_inc = bit_cnt_q;
        if (shift_ev && bit_cnt_q != CNT_W'(COLS + 1)) begin
            cnt_inc = bit_cnt_q + 1'b1;
        end

        shreg_d     = shifted;
        bit_cnt_d   = cnt_inc;
        next_row_d  = next_row_q;
        row_data_d  = row_data_q;
        row_index_d = row_index_q;
        row_valid_d = 1'b0;
        len_error_d = 1'b0;

        if (clr_lvl) begin
            shreg_d    = '0;
            bit_cnt_d  = '0;
            next_row_d = '0;
        end else if (dclk_rise) begin
            row_data_d  = shifted;
            row_index_d = next_row_q;
            next_row_d  = (next_row_q == IDX_W'(ROWS - 1)) ? '0 : next_row_q + 1'b1;
            row_valid_d = 1'b1;
            len_error_d = (cnt_inc != CNT_W'(COLS));
            bit_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            next_row_q  <= '0;
            row_data_q  <= '0;
            row_index_q <= '0;
            row_valid_q <= 1'b0;
            len_error_q <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            next_row_q  <= next_row_d;
            row_data_q  <= row_data_d;
            row_index_q <= row_index_d;
            row_valid_q <= row_valid_d;
            len_error_q <= len_error_d;
        end
    end

    assign row_data  = row_data_q;
    assign row_index = row_index_q;
    assign row_valid = row_valid_q;
    assign len_error = len_error_q;

endmodule

// File: tb/tb_display_link_rx.sv
module tb_display_link_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       serial_clock = 1'b0;
    logic       data_in = 1'b0;
    logic       data_enable = 1'b0;
    logic       display_clk = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] row_data;
    logic [2:0] row_index;
    logic       row_valid;
    logic       len_error;

    int total = 0;
    int bad   = 0;
    int rv_count = 0;

    // latch results
    int         lat_cycle;
    logic [7:0] lat_data;
    logic [2:0] lat_idx;
    logic       lat_err;

    display_link_rx #(.COLS(8), .ROWS(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .serial_clock(serial_clock), .data_in(data_in),
        .data_enable(data_enable), .display_clk(display_clk), .clear(clear),
        .row_data(row_data), .row_index(row_index), .row_valid(row_valid),
        .len_error(len_error));

    always #5 clk = ~clk;

    always @(posedge clk) if (row_valid) rv_count++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        serial_clock = 1'b0;
        data_in      = b;
        negs(8);
        serial_clock = 1'b1;
        negs(8);
    endtask

    task automatic send_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    // Raise display_clk just after a falling edge and record which following
    // rising edge first shows row_valid (edge 1 samples the pin).
    task automatic do_latch();
        @(negedge clk);
        serial_clock = 1'b0;
        negs(8);
        display_clk = 1'b1;
        lat_cycle = 0;
        lat_data  = '0;
        lat_idx   = '0;
        lat_err   = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (row_valid && lat_cycle == 0) begin
                lat_cycle = k;
                lat_data  = row_data;
                lat_idx   = row_index;
                lat_err   = len_error;
            end
        end
        @(negedge clk);
        display_clk = 1'b0;
        negs(8);
    endtask

    task automatic row_check(input string tag, input logic [7:0] d, input logic [2:0] idx,
                             input logic err, input int pc_before);
        check({tag, "_lat"}, lat_cycle, 3);
        check({tag, "_data"}, lat_data, d);
        check({tag, "_idx"}, lat_idx, idx);
        check({tag, "_err"}, lat_err, err);
        check({tag, "_pulses"}, rv_count - pc_before, 1);
    endtask

    initial begin
        int pc;
        logic [7:0] held;

        // 1: inputs toggling under reset
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            serial_clock = i[0];
            data_in      = ~i[0];
            data_enable  = 1'b1;
            display_clk  = i[1];
            clear        = i[2];
        end
        check("rst_data", row_data, 0);
        check("rst_idx", row_index, 0);
        check("rst_valid", row_valid, 0);
        check("rst_err", len_error, 0);
        @(negedge clk);
        serial_clock = 0; data_in = 0; display_clk = 0; clear = 0; data_enable = 1;
        negs(4);
        reset = 1'b1;
        pc = rv_count;
        negs(20);
        check("idle_no_valid", rv_count - pc, 0);

        // 2: full row 0xA5
        send_bits(16'hA5, 8);
        pc = rv_count;
        do_latch();
        row_check("a5", 8'hA5, 3'd0, 1'b0, pc);

        // 3: short row (5 bits 10110) keeps stale upper bits, then long row
        send_bits(16'b10110, 5);
        pc = rv_count;
        do_latch();
        row_check("short", 8'hB6, 3'd1, 1'b1, pc);
        send_bits(16'h2F3, 10);
        pc = rv_count;
        do_latch();
        row_check("long", 8'hF3, 3'd2, 1'b1, pc);

        // 4: edges with data_enable low are ignored
        data_enable = 1'b0;
        send_bits(16'h7, 3);
        pc = rv_count;
        do_latch();
        row_check("gated", 8'hF3, 3'd3, 1'b1, pc);
        data_enable = 1'b1;

        // 5: clear resets row counter, then 9 rows wrap 0..7,0
        @(negedge clk);
        clear = 1'b1;
        pc = rv_count;
        negs(8);
        check("clr_hold_data", row_data, 8'hF3);
        check("clr_no_valid", rv_count - pc, 0);
        clear = 1'b0;
        negs(8);
        for (int r = 0; r < 9; r++) begin
            logic [7:0] v;
            v = 8'h11 * r[7:0] + 8'h03;
            send_bits({8'h00, v}, 8);
            pc = rv_count;
            do_latch();
            row_check($sformatf("row%0d", r), v, r[2:0] & 3'd7, 1'b0, pc);
        end
        held = 8'h11 * 8'd8 + 8'h03;
        send_bits(16'hF, 4);
        @(negedge clk);
        serial_clock = 1'b0;
        negs(4);
        clear = 1'b1;
        pc = rv_count;
        negs(8);
        check("clr2_hold_data", row_data, held);
        check("clr2_hold_idx", row_index, 0);
        check("clr2_no_valid", rv_count - pc, 0);
        clear = 1'b0;
        negs(8);
        send_bits(16'h3C, 8);
        pc = rv_count;
        do_latch();
        row_check("postclr", 8'h3C, 3'd0, 1'b0, pc);

        // 6: asynchronous reset mid-row
        send_bits(16'h5, 3);
        @(negedge clk);
        serial_clock = 1'b0;
        data_in = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("arst_data", row_data, 0);
        check("arst_idx", row_index, 0);
        check("arst_valid", row_valid, 0);
        negs(4);
        reset = 1'b1;
        negs(4);
        send_bits(16'h5A, 8);
        pc = rv_count;
        do_latch();
        row_check("after_rst", 8'h5A, 3'd0, 1'b0, pc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
